// File: rtl/ram16k_pkg.sv
// Shared widths and controller state encoding for the RAM16K request controller.
package ram16k_pkg;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 14;
   localparam int BANK_W   = 3;
   localparam int WORD_W   = 11;
   localparam int BANK_CNT = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD   = 3'd2,
      CAP  = 3'd3,
      RESP = 3'd4
   } ctrl_state_t;
endpackage

// File: rtl/bank_dec38.sv
// 3-to-8 one-hot bank decoder with enable; all-zero output when disabled.
module bank_dec38
   import ram16k_pkg::*;
(
   input  logic                en,
   input  logic [BANK_W-1:0]   sel,
   output logic [BANK_CNT-1:0] onehot
);
   always_comb begin
      onehot = '0;
      if (en) onehot[sel] = 1'b1;
   end
endmodule

// File: rtl/ram16k_ctrl.sv
// Request-side controller for RAM16K (8 banks x 2K x 16b), all outputs registered.
// Optional RAM16K_PERF_CNT_EN adds saturating write/read-response counters.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WR    | bank_we strobe on the selected bank for one cycle
// RD    | bank_re strobe on the selected bank; bank data appears next cycle
// CAP   | mux_data sampled into rsp_rdata
// RESP  | rsp_valid held until rsp_ready
module ram16k_ctrl
   import ram16k_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [WORD_W-1:0]   bank_addr,
   output logic [DATA_W-1:0]   bank_wdata,
   output logic [BANK_CNT-1:0] bank_we,
   output logic [BANK_CNT-1:0] bank_re,
   output logic [BANK_W-1:0]   mux_sel,
   input  logic [DATA_W-1:0]   mux_data
`ifdef RAM16K_PERF_CNT_EN
   ,
   output logic [15:0]         wr_cnt,
   output logic [15:0]         rd_cnt
`endif
);
   ctrl_state_t         state_q, state_d;
   logic                accept;
   logic                req_ready_d, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_d, bank_wdata_d;
   logic [WORD_W-1:0]   bank_addr_d;
   logic [BANK_W-1:0]   mux_sel_d, dec_sel;
   logic                we_en, re_en;
   logic [BANK_CNT-1:0] we_oh, re_oh;

   assign accept = req_valid & req_ready;

   always_comb begin
      state_d      = state_q;
      rsp_valid_d  = rsp_valid;
      rsp_rdata_d  = rsp_rdata;
      bank_addr_d  = bank_addr;
      bank_wdata_d = bank_wdata;
      mux_sel_d    = mux_sel;
      dec_sel      = req_addr[ADDR_W-1 -: BANK_W];
      we_en        = 1'b0;
      re_en        = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               bank_addr_d  = req_addr[WORD_W-1:0];
               bank_wdata_d = req_wdata;
               if (req_we) begin
                  we_en   = 1'b1;
                  state_d = WR;
               end else begin
                  re_en     = 1'b1;
                  mux_sel_d = dec_sel;
                  state_d   = RD;
               end
            end
         end
         WR:   state_d = IDLE;
         RD:   state_d = CAP;
         CAP: begin
            rsp_rdata_d = mux_data;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
   end

   // Strobes are decoded from the next state's bank so they register alongside it.
   bank_dec38 u_dec_we (.en(we_en), .sel(dec_sel), .onehot(we_oh));
   bank_dec38 u_dec_re (.en(re_en), .sel(dec_sel), .onehot(re_oh));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         bank_addr  <= '0;
         bank_wdata <= '0;
         bank_we    <= '0;
         bank_re    <= '0;
         mux_sel    <= '0;
      end else begin
         state_q    <= state_d;
         req_ready  <= req_ready_d;
         rsp_valid  <= rsp_valid_d;
         rsp_rdata  <= rsp_rdata_d;
         bank_addr  <= bank_addr_d;
         bank_wdata <= bank_wdata_d;
         bank_we    <= we_oh;
         bank_re    <= re_oh;
         mux_sel    <= mux_sel_d;
      end
   end

`ifdef RAM16K_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         if (state_q == WR && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
         if (state_q == RESP && rsp_ready && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_ram16k_ctrl.sv
// Bench for ram16k_ctrl: directed requests, queued expectations, bank/mux model of RAM16K.
module tb_ram16k_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [13:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_rdata;
   logic [10:0] bank_addr;
   logic [15:0] bank_wdata;
   logic [7:0]  bank_we, bank_re;
   logic [2:0]  mux_sel;
   logic [15:0] mux_data;
`ifdef RAM16K_PERF_CNT_EN
   logic [15:0] wr_cnt, rd_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_wr = 0;
   int exp_rd = 0;

   typedef struct {
      logic [7:0]  oh;
      logic [10:0] word;
      logic [15:0] data;
      logic [2:0]  sel;
      int          acc;
   } exp_t;
   exp_t wr_q[$];
   exp_t rd_q[$];
   exp_t rsp_q[$];

   ram16k_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .bank_addr(bank_addr), .bank_wdata(bank_wdata),
      .bank_we(bank_we), .bank_re(bank_re),
      .mux_sel(mux_sel), .mux_data(mux_data)
`ifdef RAM16K_PERF_CNT_EN
      , .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read bank array plus external 8:1 mux; top word has power-on content 0x1234.
   logic [15:0] mem [0:16383];
   logic [15:0] bank_q [0:7];
   always @(posedge clk) begin
      if (rst) mem[16383] <= 16'h1234;
      for (int b = 0; b < 8; b++) begin
         if (bank_we[b]) mem[{b[2:0], bank_addr}] <= bank_wdata;
         if (bank_re[b]) bank_q[b] <= mem[{b[2:0], bank_addr}];
      end
   end
   assign mux_data = bank_q[mux_sel];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic miss(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event with no expectation / timeout (cycle %0d)", name, cyc);
   endtask

   logic        prev_v  = 1'b0;
   logic        prev_hs = 1'b0;
   logic [15:0] prev_d  = '0;

   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst) begin
         if (|bank_we && |bank_re) chk("we_re_exclusive", {bank_we, bank_re}, {bank_we, 8'h00});
         if (|bank_we) begin
            if (wr_q.size() == 0) miss("unexpected_write");
            else begin
               e = wr_q.pop_front();
               chk("bank_we", bank_we, e.oh);
               chk("wr_bank_addr", bank_addr, e.word);
               chk("bank_wdata", bank_wdata, e.data);
               chk("wr_latency", cyc, e.acc + 1);
            end
         end
         if (|bank_re) begin
            if (rd_q.size() == 0) miss("unexpected_read");
            else begin
               e = rd_q.pop_front();
               chk("bank_re", bank_re, e.oh);
               chk("mux_sel", mux_sel, e.sel);
               chk("rd_bank_addr", bank_addr, e.word);
               rsp_q.push_back(e);
            end
         end
         if (rsp_valid && !prev_v) begin
            if (rsp_q.size() == 0) miss("unexpected_rsp");
            else chk("rsp_latency", cyc, rsp_q[0].acc + 3);
         end
         if (rsp_valid && prev_v && !prev_hs) chk("rsp_stable", rsp_rdata, prev_d);
         if (rsp_valid && rsp_ready && rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.data);
            exp_rd++;
         end
      end else begin
         wr_q.delete();
         rd_q.delete();
         rsp_q.delete();
         exp_wr = 0;
         exp_rd = 0;
      end
      prev_v  = rsp_valid;
      prev_d  = rsp_rdata;
      prev_hs = rsp_valid & rsp_ready;
   end

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic send(input bit we, input logic [13:0] a, input logic [15:0] d,
                       input int bank, input logic [10:0] word, input logic [15:0] rexp,
                       input bit hold);
      exp_t e;
      int   n = 0;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      while (!req_ready) begin
         n++;
         if (n > 50) begin
            miss("req_ready_timeout");
            break;
         end
         @(negedge clk);
      end
      e.oh   = 8'(1 << bank);
      e.sel  = 3'(bank);
      e.word = word;
      e.data = we ? d : rexp;
      e.acc  = cyc;
      if (we) begin
         wr_q.push_back(e);
         exp_wr++;
      end else rd_q.push_back(e);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      forever begin
         @(negedge clk);
         #2;
         if (wr_q.size() == 0 && rd_q.size() == 0 && rsp_q.size() == 0 && req_ready && !rsp_valid)
            break;
         n++;
         if (n > 100) begin
            miss("idle_timeout");
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_bank_we", bank_we, 0);
      chk("rst_bank_re", bank_re, 0);
      chk("rst_bank_addr", bank_addr, 0);
      chk("rst_bank_wdata", bank_wdata, 0);
      chk("rst_mux_sel", mux_sel, 0);
      rst = 1'b0;
      @(negedge clk);

      // write 0x2805 -> bank5 word 0x005; req_ready back two cycles after accept
      send(1, 14'h2805, 16'hBEEF, 5, 11'h005, 16'h0000, 0);
      chk("wr_req_ready_low", req_ready, 0);
      @(negedge clk);
      chk("wr_req_ready_back", req_ready, 1);
      wait_idle();

      // read top address -> bank7 word 0x7FF
      send(0, 14'h3FFF, 16'h0000, 7, 11'h7FF, 16'h1234, 0);
      wait_idle();
      chk("mux_sel_hold_idle", mux_sel, 7);

      // back-to-back with req_valid held
      send(1, 14'h0000, 16'hA5A5, 0, 11'h000, 16'h0000, 1);
      send(0, 14'h0000, 16'h0000, 0, 11'h000, 16'hA5A5, 0);
      wait_idle();

      send(1, 14'h1ABC, 16'h5A5A, 3, 11'h2BC, 16'h0000, 0);
      send(1, 14'h07FF, 16'h0F0F, 0, 11'h7FF, 16'h0000, 0);
      wait_idle();
      send(0, 14'h07FF, 16'h0000, 0, 11'h7FF, 16'h0F0F, 0);
      wait_idle();

      // response back-pressure
      rsp_ready = 1'b0;
      send(0, 14'h1ABC, 16'h0000, 3, 11'h2BC, 16'h5A5A, 0);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stall_rsp_seen", rsp_valid, 1);
      repeat (5) begin
         @(negedge clk);
         chk("stall_req_ready", req_ready, 0);
         chk("stall_rsp_valid", rsp_valid, 1);
      end
      rsp_ready = 1'b1;
      wait_idle();

`ifdef RAM16K_PERF_CNT_EN
      chk("wr_cnt", wr_cnt, 32'(exp_wr));
      chk("rd_cnt", rd_cnt, 32'(exp_rd));
`endif

      // reset while in RD
      send(0, 14'h2805, 16'h0000, 5, 11'h005, 16'hBEEF, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_req_ready", req_ready, 1);
      chk("midrst_bank_re", bank_re, 0);
      chk("midrst_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("midrst_no_rsp", rsp_valid, 0);
      end
      send(0, 14'h2805, 16'h0000, 5, 11'h005, 16'hBEEF, 0);
      wait_idle();

`ifdef RAM16K_PERF_CNT_EN
      chk("wr_cnt_after_rst", wr_cnt, 32'(exp_wr));
      chk("rd_cnt_after_rst", rd_cnt, 32'(exp_rd));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
